i2c_master: RTL

I2C_MASTER -- requirements
Module: i2c_master

---
 rtl/i2c_master.sv | 299 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_master.sv
// ---------------------------------------------------------------------------
// i2c_master
//
// Single-byte I2C master.
// One transaction is START, address byte plus R/W bit, slave ACK, then one
// data byte (written, or read and NACKed), then STOP.
// Bus timing comes from a quarter-bit counter:
//   - every bit period is four quarters Q0..Q3 of CLK_DIV clks each;
//   - SCL is low in Q0-Q1 and released in Q2-Q3;
//   - SDA changes on Q0 entry and is sampled on the Q2->Q3 boundary.
// Clock stretching is not supported.
//
// Parameters
//   CLK_DIV : clk cycles per SCL quarter-bit (1..255)
//
// Ports
//   clk     : system clock, rising edge
//   rst     : asynchronous, active-high reset
//   start   : transaction request, accepted only when idle and not in the
//             done cycle
//   addr    : 7-bit target address, captured with start
//   rw      : 1 = read, 0 = write, captured with start
//   wdata   : byte to write, captured with start
//   rdata   : last byte read; kept across write and NACKed transactions
//   busy    : high while a transaction is in progress
//   done    : one-clk pulse when STOP completes
//   nack    : address or write-data phase saw no ACK; held until next start
//   sda     : open-drain data line, drives only 0 or z
//   scl     : open-drain clock line, drives only 0 or z
// ---------------------------------------------------------------------------
module i2c_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       nack,
    inout  wire        sda,
    output logic       scl
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WRITE,
        ST_WRITE_ACK,
        ST_READ,
        ST_READ_ACK,
        ST_STOP
    } state_t;

    localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;          // clks within the current quarter
    logic [1:0]  quarter_q, quarter_d;  // Q0..Q3 within the current bit
    logic [2:0]  bit_q, bit_d;          // bit index within a byte
    logic [7:0]  tx_q, tx_d;            // outgoing shift register, MSB on the bus
    logic [7:0]  rx_q, rx_d;            // incoming shift register
    logic [7:0]  wdata_q, wdata_d;
    logic        rw_q, rw_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        nack_q, nack_d;
    logic        samp_q, samp_d;        // SDA value taken at the last Q2->Q3 boundary
    logic        sda_meta_q, sda_meta_d;
    logic        sda_s_q, sda_s_d;      // SDA after a two-flop synchronizer
    logic        sda_oe_q, sda_oe_d;    // 1 = pull SDA low
    logic        scl_oe_q, scl_oe_d;    // 1 = pull SCL low

    logic        tick;
    logic        sample_pt;
    logic        bit_end;

    // Open-drain pads: the only driven level is 0.
    assign sda   = sda_oe_q ? 1'b0 : 1'bz;
    assign scl   = scl_oe_q ? 1'b0 : 1'bz;

    assign rdata = rdata_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign nack  = nack_q;

    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so
        // no path leaves one unassigned and no latch can be inferred.
        state_d    = state_q;
        div_d      = div_q;
        quarter_d  = quarter_q;
        bit_d      = bit_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        wdata_d    = wdata_q;
        rw_d       = rw_q;
        rdata_d    = rdata_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        nack_d     = nack_q;
        samp_d     = samp_q;
        sda_meta_d = sda;
        sda_s_d    = sda_meta_q;
        sda_oe_d   = 1'b0;
        scl_oe_d   = 1'b0;

        tick      = (div_q == DIV_MAX);
        sample_pt = tick && (quarter_q == 2'd2);
        bit_end   = tick && (quarter_q == 2'd3);

        // The quarter timer only runs during a transaction; quarter_q wraps
        // from 3 back to 0 by its own width at the end of each bit.
        if (state_q != ST_IDLE) begin
            div_d = tick ? 8'd0 : div_q + 8'd1;
            if (tick) begin
                quarter_d = quarter_q + 2'd1;
            end
        end

        if (sample_pt) begin
            samp_d = sda_s_q;
        end

        case (state_q)
            ST_IDLE: begin
                // The done cycle is excluded so a held start produces a clean
                // one-clk gap between transactions.
                if (start && !done_q) begin
                    state_d   = ST_START;
                    tx_d      = {addr, rw};
                    rw_d      = rw;
                    wdata_d   = wdata;
                    nack_d    = 1'b0;
                    busy_d    = 1'b1;
                    div_d     = 8'd0;
                    quarter_d = 2'd0;
                    bit_d     = 3'd0;
                end
            end

            ST_START: begin
                if (bit_end) begin
                    state_d = ST_ADDR;
                end
            end

            ST_ADDR: begin
                if (bit_end) begin
                    tx_d  = {tx_q[6:0], 1'b0};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_ADDR_ACK;
                    end
                end
            end

            ST_ADDR_ACK: begin
                if (bit_end) begin
                    bit_d = 3'd0;
                    if (samp_q) begin
                        nack_d  = 1'b1;
                        state_d = ST_STOP;
                    end else if (rw_q) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_WRITE;
                        tx_d    = wdata_q;
                    end
                end
            end

            ST_WRITE: begin
                if (bit_end) begin
                    tx_d  = {tx_q[6:0], 1'b0};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_WRITE_ACK;
                    end
                end
            end

            ST_WRITE_ACK: begin
                if (bit_end) begin
                    nack_d  = samp_q;
                    state_d = ST_STOP;
                end
            end

            ST_READ: begin
                if (sample_pt) begin
                    rx_d = {rx_q[6:0], sda_s_q};
                    // rdata only ever sees a complete byte.
                    if (bit_q == 3'd7) begin
                        rdata_d = {rx_q[6:0], sda_s_q};
                    end
                end
                if (bit_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_READ_ACK;
                    end
                end
            end

            ST_READ_ACK: begin
                // SDA stays released: single-byte read, the master NACKs.
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end

            ST_STOP: begin
                if (bit_end) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // The pad enables are decoded from the next state so that they are
        // registered and change cleanly on the same edge as the state.
        case (state_d)
            ST_START: begin
                sda_oe_d = quarter_d[1];
            end
            ST_ADDR, ST_WRITE: begin
                scl_oe_d = ~quarter_d[1];
                sda_oe_d = ~tx_d[7];
            end
            ST_ADDR_ACK, ST_WRITE_ACK, ST_READ, ST_READ_ACK: begin
                scl_oe_d = ~quarter_d[1];
            end
            ST_STOP: begin
                scl_oe_d = ~quarter_d[1];
                sda_oe_d = (quarter_d != 2'd3);
            end
            default: begin
                scl_oe_d = 1'b0;
                sda_oe_d = 1'b0;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the values from before this edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            div_q      <= 8'd0;
            quarter_q  <= 2'd0;
            bit_q      <= 3'd0;
            tx_q       <= 8'd0;
            rx_q       <= 8'd0;
            wdata_q    <= 8'd0;
            rw_q       <= 1'b0;
            rdata_q    <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            nack_q     <= 1'b0;
            samp_q     <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_s_q    <= 1'b1;
            sda_oe_q   <= 1'b0;
            scl_oe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            quarter_q  <= quarter_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            wdata_q    <= wdata_d;
            rw_q       <= rw_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            nack_q     <= nack_d;
            samp_q     <= samp_d;
            sda_meta_q <= sda_meta_d;
            sda_s_q    <= sda_s_d;
            sda_oe_q   <= sda_oe_d;
            scl_oe_q   <= scl_oe_d;
        end
    end

endmodule
